alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//  Shares the single combinational 16-bit ALU (4-bit opcode select) between two requesters.
//  - Arbitrates round-robin and registers the granted operands and opcode onto the ALU inputs.
//  - Captures the ALU result one cycle later and returns it with zero/negative flags over a valid/ready response channel.
//  - Sits between the instruction-side and address-side issue logic and the shared ALU instance.
// PARAMETERS
//  DW         16  operand/result width; must equal ALU width
//  OPW        4   opcode width; must equal ALU select width
//  RST_LAST   1   reset value of last-grant pointer (1 => req0 wins first contention)
// PORTS
//  clk          in   1    single clock, rising edge
//  rst          in   1    synchronous reset, active-high
//  req0_valid   in   1    requester 0 has an operation
//  req0_ready   out  1    requester 0 accepted this cycle (valid&ready = handshake)
//  req0_op      in   OPW  requester 0 opcode
//  req0_a       in   DW   requester 0 operand a
//  req0_b       in   DW   requester 0 operand b
//  req1_*       --   --   identical set for requester 1
//  alu_s        out  OPW  opcode to ALU select
//  alu_a        out  DW   operand a to ALU
//  alu_b        out  DW   operand b to ALU
//  alu_out      in   DW   ALU result (combinational from alu_s/alu_a/alu_b)
//  rsp_valid    out  1    response holds a result
//  rsp_ready    in   1    consumer takes response
//  rsp_id       out  1    requester index that owns the response
//  rsp_data     out  DW   captured ALU result
//  rsp_zero     out  1    rsp_data == 0
//  rsp_neg      out  1    rsp_data[DW-1]
// BEHAVIOUR
//  - FSM states:
//    - IDLE -> EXEC on any grant.
//    - EXEC -> RESP unconditionally.
//    - RESP -> IDLE on rsp_valid&rsp_ready.
//  - Ready signals:
//    - reqN_ready is combinational; only in IDLE; only the granted requester is high; at most one high per cycle.
//  - Grant rules:
//    - One valid: grant it.
//    - Both valid: grant the one != last_grant; last_grant updates on every grant.
//  - Handshake cycle t (IDLE): alu_s/alu_a/alu_b and rsp_id registered from the winner.
//  - EXEC (t+1): alu_out captured into rsp_data, and rsp_zero/rsp_neg derived from that same captured value.
//  - RESP: rsp_valid=1 from t+2. rsp_data/id/flags held stable until accepted.
//  - Latency and throughput:
//    - Minimum latency is 2 cycles from handshake to rsp_valid.
//    - Throughput is 1 op per 3 cycles at best (rsp_ready tied high).
//  - No back-to-back acceptance: a request arriving in RESP waits; the consumer must not see a response change while rsp_valid&!rsp_ready.
//  - alu_s/a/b hold their last values outside EXEC (no glitching of the ALU inputs).
//  - Requester may drop valid before handshake; no request is latched without a handshake.
//  - Arithmetic: pure pass-through of the ALU result, modulo 2^DW; no carry/overflow produced.
//  - Reset values (any state, mid-operation included):
//    - state=IDLE; in-flight op dropped with no response.
//    - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=1, rsp_neg=0.
//    - alu_s=0, alu_a=0, alu_b=0.
//    - last_grant=RST_LAST.
//  - rst has priority over every handshake in the same cycle.
// CONFIGURATION
//  ALU_ARB_STATS_EN defined:
//   - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each).
//   - Each counter increments on its requester's handshake and saturates at 16'hFFFF.
//   - Counters clear to 0 on rst.
//  ALU_ARB_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  - Single op: req0 op=0 a=64 b=32, rsp_ready=1.
//    -> rsp_valid 2 cycles after handshake, rsp_data=96, id=0, zero=0, neg=0.
//  - Ops 1/2/3 on req1 with a=64 b=32, each in turn:
//    -> 32; 16'hFFE0 with neg=1; 0 with zero=1; id=1 each time.
//  - Contention: both valid from reset, op=14 (and) on req0 and op=15 (or) on req1, a=64 b=32.
//    -> req0 granted first (rsp 0), then req1 (rsp 96); grants alternate while both stay valid.
//  - Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
//    -> rsp_data/id/flags stable, both reqN_ready=0 throughout; accepted on first rsp_ready=1, IDLE next cycle.
//  - Reset in EXEC: assert rst one cycle after handshake.
//    -> no response ever appears; outputs at reset values; next request served normally.
//  - With ALU_ARB_STATS_EN: 3 req0 + 2 req1 handshakes -> grant_cnt0=3, grant_cnt1=2; rst -> both 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters.
// Defining ALU_ARB_STATS_EN adds saturating per-requester grant counters.
module alu_arbiter #(
   parameter int DW       = 16,
   parameter int OPW      = 4,
   parameter bit RST_LAST = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [OPW-1:0] req0_op,
   input  logic [DW-1:0]  req0_a,
   input  logic [DW-1:0]  req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [OPW-1:0] req1_op,
   input  logic [DW-1:0]  req1_a,
   input  logic [DW-1:0]  req1_b,
   output logic [OPW-1:0] alu_s,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   input  logic [DW-1:0]  alu_out,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [DW-1:0]  rsp_data,
   output logic           rsp_zero,
   output logic           rsp_neg
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]    grant_cnt0,
   output logic [15:0]    grant_cnt1
`endif
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state;
   logic last_grant, gnt0, gnt1;
   always_comb begin
      gnt0 = req0_valid & (!req1_valid | last_grant);
      gnt1 = req1_valid & (!req0_valid | !last_grant);
   end
   assign req0_ready = (state == IDLE) & gnt0;
   assign req1_ready = (state == IDLE) & gnt1;
   // ALU inputs change only on a grant, so they stay quiet in EXEC and RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= RST_LAST;
         alu_s      <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         rsp_zero   <= 1'b1;
         rsp_neg    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (gnt0 | gnt1) begin
               state      <= EXEC;
               last_grant <= gnt1;
               rsp_id     <= gnt1;
               alu_s      <= gnt1 ? req1_op : req0_op;
               alu_a      <= gnt1 ? req1_a : req0_a;
               alu_b      <= gnt1 ? req1_b : req0_b;
            end
            EXEC: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_data  <= alu_out;
               rsp_zero  <= alu_out == '0;
               rsp_neg   <= alu_out[DW-1];
            end
            RESP: if (rsp_ready) begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef ALU_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (req0_ready && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
         if (req1_ready && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
      end
   end
`endif
endmodule
